// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath word width and default data-memory depth.
package cpu_pkg;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DMEM_DEPTH = 32;
endpackage

// File: rtl/data_mem.sv
// Word-organised data memory for the MEM stage: synchronous write, combinational read.
// Optional macro DMEM_RANGE_CHECK_EN drops misaligned/out-of-range accesses instead of wrapping.
module data_mem
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = DMEM_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  output logic [31:0]       data_o
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              access_ok;

  assign idx = addr_i[ADDR_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign access_ok = (addr_i[1:0] == 2'b00) && (addr_i < 32'(DEPTH * 4));
`else
  // Byte offset and high address bits are don't-care: forced alignment and wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign access_ok        = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (MemWrite_i && access_ok) begin
      mem[idx] <= data_i;
    end
  end

  always_comb begin
    data_o = '0;
    if (MemRead_i && access_ok) begin
      data_o = mem[idx];
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus queues expected read data, a monitor compares.
module tb_data_mem;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        MemWrite_i;
  logic        MemRead_i;
  logic [31:0] data_o;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  data_mem #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .MemWrite_i (MemWrite_i),
    .MemRead_i  (MemRead_i),
    .data_o     (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Monitor: compares the presented read data against the head of the queue.
  initial begin
    forever begin
      @(sample_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: data_o=%08h with nothing expected", data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_o !== e.exp) begin
          errors++;
          $display("FAIL %s: data_o=%08h expected=%08h", e.name, data_o, e.exp);
        end
      end
    end
  end

  task automatic edge_step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr_i     = a;
    data_i     = d;
    MemWrite_i = 1'b1;
    MemRead_i  = 1'b0;
    edge_step();
    MemWrite_i = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic rd,
                          input logic [31:0] exp);
    exp_t e;
    addr_i    = a;
    MemRead_i = rd;
    #1;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  initial begin
    rst_i      = 1'b0;
    addr_i     = '0;
    data_i     = '0;
    MemWrite_i = 1'b0;
    MemRead_i  = 1'b0;
    edge_step();

    // Preload a word so the reset clear is observable.
    do_write(32'd4, 32'h0000_00AA);
    read_chk("preload_4", 32'd4, 1'b1, 32'h0000_00AA);

    rst_i = 1'b1;
    edge_step();
    rst_i = 1'b0;
    read_chk("reset_0",   32'd0,   1'b1, 32'h0);
    read_chk("reset_4",   32'd4,   1'b1, 32'h0);
    read_chk("reset_124", 32'd124, 1'b1, 32'h0);

    do_write(32'd0, 32'd10);
    read_chk("write_0",      32'd0, 1'b1, 32'd10);
    read_chk("read_disable", 32'd0, 1'b0, 32'h0);

    do_write(32'd8,  32'hDEAD_BEEF);
    do_write(32'd12, 32'h1234_5678);
    read_chk("word_8",  32'd8,  1'b1, 32'hDEAD_BEEF);
    read_chk("word_12", 32'd12, 1'b1, 32'h1234_5678);
    read_chk("word_4",  32'd4,  1'b1, 32'h0);

    // Same-cycle write and read of word 8.
    addr_i     = 32'd8;
    data_i     = 32'h55;
    MemWrite_i = 1'b1;
    read_chk("rw_before_edge", 32'd8, 1'b1, 32'hDEAD_BEEF);
    edge_step();
    MemWrite_i = 1'b0;
    read_chk("rw_after_edge", 32'd8, 1'b1, 32'h55);

    do_write(32'd128, 32'd7);
`ifdef DMEM_RANGE_CHECK_EN
    read_chk("oob_write_dropped", 32'd0,   1'b1, 32'd10);
    read_chk("misaligned_read",   32'd2,   1'b1, 32'h0);
    read_chk("oob_read",          32'd128, 1'b1, 32'h0);
`else
    read_chk("wrap_write",        32'd0,   1'b1, 32'd7);
    read_chk("misaligned_read",   32'd2,   1'b1, 32'd7);
    read_chk("wrap_read",         32'd136, 1'b1, 32'h55);
`endif

    // Reset coincident with a write: reset wins.
    addr_i     = 32'd0;
    data_i     = 32'd9;
    MemWrite_i = 1'b1;
    rst_i      = 1'b1;
    edge_step();
    rst_i      = 1'b0;
    MemWrite_i = 1'b0;
    read_chk("reset_vs_write", 32'd0,  1'b1, 32'h0);
    read_chk("reset_clears_8", 32'd8,  1'b1, 32'h0);
    read_chk("reset_clears_12", 32'd12, 1'b1, 32'h0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
